// File: rtl/alu_arbiter_2p_pkg.sv
// Shared ALU definitions: control codes, default widths, port identifiers
// and the supported-operation check used by the arbiter.
package alu_pkg;

    localparam int unsigned ALU_WIDTH  = 32;
    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'd12;
    localparam logic [ALU_CTRL_W-1:0] ALU_ORI = 4'd13;

    // Identifies which requester holds (or last held) the shared ALU.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // True for the control codes the alu_mips instance implements.
    function automatic logic alu_ctrl_supported(input logic [ALU_CTRL_W-1:0] ctrl);
        logic ok;
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
            ALU_SLT, ALU_NOR, ALU_ORI: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_arbiter_2p_rsp_slot.sv
// One-entry response register with a valid/ready output handshake.
// A load wins over a same-cycle take, so a full slot can drain and refill
// on one edge; data and flags hold while valid and not taken.
module alu_rsp_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             zero_i,
    input  logic             err_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             err_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             zero_q,  zero_d;
    logic             err_q,   err_d;

    // Next-state: capture on load, otherwise release on consumer take.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        zero_d  = zero_q;
        err_d   = err_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            zero_d  = zero_i;
            err_d   = err_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers, cleared asynchronously so a held result is discarded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign zero_o  = zero_q;
    assign err_o   = err_q;

endmodule

// File: rtl/alu_arbiter_2p.sv
// Two-port round-robin arbiter in front of a shared combinational alu_mips.
// The granted port's operands drive the ALU this cycle and the result is
// captured into that port's response slot on the same edge.
module alu_arbiter_2p
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = ALU_WIDTH,
    parameter int unsigned CTRL_W = ALU_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_data,
    output logic              rsp0_zero,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_data,
    output logic              rsp1_zero,
    output logic              rsp1_err,

    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_zero
);

    port_e last_grant_q, last_grant_d;
    logic  elig0, elig1;
    logic  grant0, grant1;
    logic  op_err;

    // Eligibility and round-robin grant; a slot being drained this cycle counts as free.
    always_comb begin
        elig0  = req0_valid & (~rsp0_valid | rsp0_ready);
        elig1  = req1_valid & (~rsp1_valid | rsp1_ready);
        grant0 = elig0 & (~elig1 | (last_grant_q == PORT1));
        grant1 = elig1 & (~elig0 | (last_grant_q == PORT0));
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Shared ALU input mux; idles at AND of zeros when nobody is granted.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        if (grant0) begin
            alu_a       = req0_a;
            alu_b       = req0_b;
            alu_control = req0_ctrl;
        end else if (grant1) begin
            alu_a       = req1_a;
            alu_b       = req1_b;
            alu_control = req1_ctrl;
        end
    end

    // Error flag follows the code actually presented to the ALU.
    assign op_err = ~alu_ctrl_supported(ALU_CTRL_W'(alu_control));

    // Round-robin pointer moves only on a real grant.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = PORT0;
        end else if (grant1) begin
            last_grant_d = PORT1;
        end
    end

    // Pointer register; resets to port 1 so port 0 wins the first contest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= PORT1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    alu_rsp_slot #(
        .WIDTH (WIDTH)
    ) u_rsp0 (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (grant0),
        .data_i  (alu_out),
        .zero_i  (alu_zero),
        .err_i   (op_err),
        .ready_i (rsp0_ready),
        .valid_o (rsp0_valid),
        .data_o  (rsp0_data),
        .zero_o  (rsp0_zero),
        .err_o   (rsp0_err)
    );

    alu_rsp_slot #(
        .WIDTH (WIDTH)
    ) u_rsp1 (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (grant1),
        .data_i  (alu_out),
        .zero_i  (alu_zero),
        .err_i   (op_err),
        .ready_i (rsp1_ready),
        .valid_o (rsp1_valid),
        .data_o  (rsp1_data),
        .zero_o  (rsp1_zero),
        .err_o   (rsp1_err)
    );

endmodule

// File: tb/tb_alu_arbiter_2p.sv
// Bench for alu_arbiter_2p: behavioural ALU and arbiter model plus directed
// vectors with hand-computed expectations.
module tb_alu_arbiter_2p;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_control;
    logic        alu_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter_2p #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    // Behavioural alu_mips: unsupported codes give 0 (so zero=1).
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd4:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            4'd13:   return a | {16'h0000, b[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out  = alu_ref(alu_a, alu_b, alu_control);
    assign alu_zero = (alu_out == 32'd0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: who won last, and what each response buffer holds.
    int          m_last = 1;
    bit          m_val[2];
    logic [31:0] m_data[2];
    bit          m_zero[2];
    bit          m_err[2];

    // Which port the rules pick right now: -1 none.
    function automatic int exp_grant();
        bit e0, e1;
        e0 = req0_valid && (!m_val[0] || rsp0_ready);
        e1 = req1_valid && (!m_val[1] || rsp1_ready);
        if (e0 && e1) return (m_last == 0) ? 1 : 0;
        if (e0)       return 0;
        if (e1)       return 1;
        return -1;
    endfunction

    function automatic bit supported(input logic [3:0] c);
        return c inside {4'd0, 4'd1, 4'd4, 4'd6, 4'd7, 4'd12, 4'd13};
    endfunction

    // Model update on each clock edge or reset.
    initial begin
        m_val  = '{0, 0};
        m_data = '{32'd0, 32'd0};
        m_zero = '{0, 0};
        m_err  = '{0, 0};
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_last = 1;
                for (int p = 0; p < 2; p++) begin
                    m_val[p] = 0; m_data[p] = '0; m_zero[p] = 0; m_err[p] = 0;
                end
            end else begin
                int g;
                logic [31:0] r;
                g = exp_grant();
                for (int p = 0; p < 2; p++) begin
                    if (g == p) begin
                        r = (p == 0) ? alu_ref(req0_a, req0_b, req0_ctrl)
                                     : alu_ref(req1_a, req1_b, req1_ctrl);
                        m_val[p]  = 1;
                        m_data[p] = r;
                        m_zero[p] = (r == 32'd0);
                        m_err[p]  = !supported((p == 0) ? req0_ctrl : req1_ctrl);
                    end else if ((p == 0) ? rsp0_ready : rsp1_ready) begin
                        m_val[p] = 0;
                    end
                end
                if (g >= 0) m_last = g;
            end
        end
    end

    // Compare process: every falling edge outside reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                int g;
                g = exp_grant();
                check("req0_ready", 32'(req0_ready), 32'(g == 0));
                check("req1_ready", 32'(req1_ready), 32'(g == 1));
                check("alu_a", alu_a, (g == 0) ? req0_a : (g == 1) ? req1_a : 32'd0);
                check("alu_b", alu_b, (g == 0) ? req0_b : (g == 1) ? req1_b : 32'd0);
                check("alu_control", 32'(alu_control),
                      32'((g == 0) ? req0_ctrl : (g == 1) ? req1_ctrl : 4'd0));
                check("rsp0_valid", 32'(rsp0_valid), 32'(m_val[0]));
                check("rsp0_data",  rsp0_data,       m_data[0]);
                check("rsp0_zero",  32'(rsp0_zero),  32'(m_zero[0]));
                check("rsp0_err",   32'(rsp0_err),   32'(m_err[0]));
                check("rsp1_valid", 32'(rsp1_valid), 32'(m_val[1]));
                check("rsp1_data",  rsp1_data,       m_data[1]);
                check("rsp1_zero",  32'(rsp1_zero),  32'(m_zero[1]));
                check("rsp1_err",   32'(rsp1_err),   32'(m_err[1]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus with literal expectations.
    initial begin
        bit exp1[4];
        exp1 = '{1, 0, 1, 0};

        #1 reset = 1'b1;
        #10;
        check("reset rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("reset rsp0_data",  rsp0_data,       32'd0);
        check("reset rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("reset rsp1_err",   32'(rsp1_err),   32'd0);
        #1 reset = 1'b0;
        cyc();

        // Port 0 alone: 5 + 3.
        req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'd4; req0_valid = 1'b1;
        #1 check("add req0_ready", 32'(req0_ready), 32'd1);
        cyc();
        check("add rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("add rsp0_data",  rsp0_data,       32'd8);
        check("add rsp0_zero",  32'(rsp0_zero),  32'd0);
        check("add rsp0_err",   32'(rsp0_err),   32'd0);
        req0_valid = 1'b0;
        cyc();

        // Both ports SUB every cycle; last winner was port 0, so 1,0,1,0.
        req0_a = 32'd7; req0_b = 32'd7; req0_ctrl = 4'd6;
        req1_a = 32'd9; req1_b = 32'd2; req1_ctrl = 4'd6;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt req1_ready", 32'(req1_ready), 32'(exp1[k]));
            check("alt req0_ready", 32'(req0_ready), 32'(!exp1[k]));
            cyc();
        end
        check("sub rsp0_data", rsp0_data,      32'd0);
        check("sub rsp0_zero", 32'(rsp0_zero), 32'd1);
        check("sub rsp1_data", rsp1_data,      32'd7);
        check("sub rsp1_zero", 32'(rsp1_zero), 32'd0);

        // Port 1 back-pressured after one result.
        req0_a = 32'd1;  req0_b = 32'd2; req0_ctrl = 4'd1;
        req1_a = 32'd20; req1_b = 32'd5; req1_ctrl = 4'd4;
        rsp1_ready = 1'b0;
        #1 check("bp first req1_ready", 32'(req1_ready), 32'd1);
        cyc();
        check("bp rsp1_data", rsp1_data, 32'd25);
        req1_a = 32'd30;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp req1_ready", 32'(req1_ready), 32'd0);
            check("bp req0_ready", 32'(req0_ready), 32'd1);
            cyc();
            check("bp rsp1_hold", rsp1_data, 32'd25);
            check("bp rsp0_data", rsp0_data, 32'd3);
        end
        rsp1_ready = 1'b1;
        #1;
        check("refill rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("refill req1_ready", 32'(req1_ready), 32'd1);
        cyc();
        check("refill rsp1_data", rsp1_data, 32'd35);
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc();

        // Unsupported control code on port 0.
        req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 4'd9; req0_valid = 1'b1;
        #1 check("bad req0_ready", 32'(req0_ready), 32'd1);
        cyc();
        check("bad rsp0_data", rsp0_data,      32'd0);
        check("bad rsp0_zero", 32'(rsp0_zero), 32'd1);
        check("bad rsp0_err",  32'(rsp0_err),  32'd1);
        req0_ctrl = 4'd4;
        cyc();
        check("good rsp0_data", rsp0_data,     32'd2);
        check("good rsp0_err",  32'(rsp0_err), 32'd0);
        req0_valid = 1'b0;

        // Idle: ALU parked at AND 0,0; pointer must not move.
        for (int k = 0; k < 3; k++) begin
            #1;
            check("idle alu_control", 32'(alu_control), 32'd0);
            check("idle alu_a",       alu_a,            32'd0);
            check("idle alu_b",       alu_b,            32'd0);
            cyc();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("post-idle req1_ready", 32'(req1_ready), 32'd1);
        check("post-idle req0_ready", 32'(req0_ready), 32'd0);
        cyc();

        // Asynchronous reset with a result held in port 0.
        req1_valid = 1'b0; rsp0_ready = 1'b0;
        cyc();
        check("pre-reset rsp0_valid", 32'(rsp0_valid), 32'd1);
        req0_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("async rsp0_data",  rsp0_data,       32'd0);
        check("async rsp0_zero",  32'(rsp0_zero),  32'd0);
        check("async rsp0_err",   32'(rsp0_err),   32'd0);
        check("async rsp1_valid", 32'(rsp1_valid), 32'd0);
        #3 reset = 1'b0;
        rsp0_ready = 1'b1;
        cyc();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("post-reset req0_ready", 32'(req0_ready), 32'd1);
        check("post-reset req1_ready", 32'(req1_ready), 32'd0);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
